// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the register-file read stage and the RV32M mul/div unit.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_start;
  logic [2:0]       i_funct3;
  logic [WIDTH-1:0] i_operandA;
  logic [WIDTH-1:0] i_operandB;
  logic [4:0]       i_rd;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;
  logic [4:0]       o_rd;

  modport master (
    output i_start, i_funct3, i_operandA, i_operandB, i_rd,
    input  o_busy, o_valid, o_result, o_rd
  );

  modport slave (
    input  i_start, i_funct3, i_operandA, i_operandB, i_rd,
    output o_busy, o_valid, o_result, o_rd
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// on operand magnitudes with the result sign applied on the final iteration.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           i_clk,
  input logic           i_srst,
  mul_div_unit_if.slave bus
);
  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [2:0]       op;
  logic [4:0]       rd;
  logic             neg;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0]    p;   // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0] m;   // multiplicand or divisor magnitude

  logic             a_sgn, b_sgn, a_neg, b_neg, res_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, fast;
  logic [WIDTH-1:0] fast_res;

  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   add_sum, sub_diff;
  logic [W2-1:0]    p_step, p_signed;
  logic [WIDTH-1:0] div_sel, res_step;

  // Request decode: signedness, magnitudes, result sign and division fast paths.
  always_comb begin
    a_sgn    = bus.i_funct3[2] ? ~bus.i_funct3[0] : (bus.i_funct3[1:0] != 2'b11);
    b_sgn    = bus.i_funct3[2] ? ~bus.i_funct3[0] : ~bus.i_funct3[1];
    a_neg    = a_sgn & bus.i_operandA[WIDTH-1];
    b_neg    = b_sgn & bus.i_operandB[WIDTH-1];
    a_mag    = a_neg ? (WIDTH'(0) - bus.i_operandA) : bus.i_operandA;
    b_mag    = b_neg ? (WIDTH'(0) - bus.i_operandB) : bus.i_operandB;
    res_neg  = (bus.i_funct3[2] & bus.i_funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = bus.i_funct3[2] && (bus.i_operandB == '0);
    div_ovf  = bus.i_funct3[2] && !bus.i_funct3[0] &&
               (bus.i_operandA == INT_MIN) && (bus.i_operandB == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_res = bus.i_funct3[1] ? bus.i_operandA : '1;
    else          fast_res = bus.i_funct3[1] ? '0 : INT_MIN;
  end

  // One iteration of the datapath plus the signed result it would produce if it were the last.
  always_comb begin
    mul_addend = p[0] ? m : '0;
    add_sum    = {1'b0, p[W2-1:WIDTH]} + {1'b0, mul_addend};
    sub_diff   = {p[W2-1:WIDTH], p[WIDTH-1]} - {1'b0, m};
    if (!op[2])             p_step = {add_sum, p[WIDTH-1:1]};
    else if (!sub_diff[WIDTH]) p_step = {sub_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    else                    p_step = {p[W2-2:0], 1'b0};

    p_signed = neg ? (W2'(0) - p_step) : p_step;
    div_sel  = op[1] ? p_step[W2-1:WIDTH] : p_step[WIDTH-1:0];
    if (!op[2]) res_step = (op[1:0] == 2'b00) ? p_signed[WIDTH-1:0] : p_signed[W2-1:WIDTH];
    else        res_step = neg ? (WIDTH'(0) - div_sel) : div_sel;
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state        <= IDLE;
      op           <= '0;
      rd           <= '0;
      neg          <= 1'b0;
      cnt          <= '0;
      p            <= '0;
      m            <= '0;
      bus.o_busy   <= 1'b0;
      bus.o_valid  <= 1'b0;
      bus.o_result <= '0;
      bus.o_rd     <= '0;
    end else begin
      bus.o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            op         <= bus.i_funct3;
            rd         <= bus.i_rd;
            neg        <= res_neg;
            cnt        <= '0;
            p          <= {WIDTH'(0), a_mag};
            m          <= b_mag;
            bus.o_busy <= 1'b1;
            if (fast) begin
              state        <= DONE;
              bus.o_valid  <= 1'b1;
              bus.o_result <= fast_res;
              bus.o_rd     <= bus.i_rd;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          p   <= p_step;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state        <= DONE;
            bus.o_valid  <= 1'b1;
            bus.o_result <= res_step;
            bus.o_rd     <= rd;
          end
        end
        DONE: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M cases plus a randomized sweep against
// a 64-bit arithmetic reference model.
`timescale 1ns/1ps
module tb_mul_div_unit;
  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned due;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        srst;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_div_unit_if #(.WIDTH(WIDTH)) bus ();
  mul_div_unit #(.WIDTH(WIDTH)) dut (.i_clk(clk), .i_srst(srst), .bus(bus));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] prod;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin prod = sa * sb; return prod[31:0]; end
      3'd1: begin prod = sa * sb; return prod[63:32]; end
      3'd2: begin prod = sa * ub; return prod[63:32]; end
      3'd3: begin prod = ua * ub; return prod[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        prod = sa / sb; return prod[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        prod = ua / ub; return prod[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        prod = sa % sb; return prod[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        prod = ua % ub; return prod[31:0];
      end
    endcase
  endfunction

  function automatic int unsigned latency(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return WIDTH + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.i_start    = 1'b1;
    bus.i_funct3   = f;
    bus.i_operandA = a;
    bus.i_operandB = b;
    bus.i_rd       = rd;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (bus.o_busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (bus.o_busy) fail_now("busy_timeout");
  endtask

  task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res);
    @(negedge clk);
    wait_idle();
    drive(f, a, b, rd);
    sbq.push_back('{res, rd, cyc + latency(f, a, b), name});
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sbq.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (sbq.size() != 0) begin
      fail_now("drain_timeout");
      sbq.delete();
    end
  endtask

  // Monitor: every o_valid pops one expected response and checks value, rd and timing.
  initial begin : monitor
    bit   prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!srst && bus.o_valid) begin
        check("valid_single_cycle", 64'(prev_valid), 64'd0);
        if (sbq.size() == 0) begin
          fail_now("unexpected_valid");
        end else begin
          e = sbq.pop_front();
          check({e.name, "_result"}, 64'(bus.o_result), 64'(e.res));
          check({e.name, "_rd"}, 64'(bus.o_rd), 64'(e.rd));
          check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
          check({e.name, "_busy"}, 64'(bus.o_busy), 64'd1);
        end
      end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
        fail_now({sbq[0].name, "_missing_valid"});
        void'(sbq.pop_front());
      end
      prev_valid = bus.o_valid;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    bit          accepted2;

    srst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_funct3 = '0;
    bus.i_operandA = '0;
    bus.i_operandB = '0;
    bus.i_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(bus.o_busy), 64'd0);
    check("reset_valid", 64'(bus.o_valid), 64'd0);
    check("reset_result", 64'(bus.o_result), 64'd0);
    check("reset_rd", 64'(bus.o_rd), 64'd0);

    issue("mul_m1x7",     3'd0, 32'hFFFF_FFFF, 32'd7, 5'd1, 32'hFFFF_FFF9);
    issue("mulh_m1x7",    3'd1, 32'hFFFF_FFFF, 32'd7, 5'd2, 32'hFFFF_FFFF);
    issue("mulhu_m1x7",   3'd3, 32'hFFFF_FFFF, 32'd7, 5'd3, 32'h0000_0006);
    issue("mulhsu_m1x2",  3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF);
    issue("mul_bzero",    3'd0, 32'h1234_5678, 32'd0, 5'd5, 32'd0);
    issue("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD);
    issue("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF);
    issue("divu_100_7",   3'd5, 32'd100, 32'd7, 5'd8, 32'd14);
    issue("remu_100_7",   3'd7, 32'd100, 32'd7, 5'd9, 32'd2);
    issue("divu_by0",     3'd5, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF);
    issue("rem_by0",      3'd6, 32'd5, 32'd0, 5'd11, 32'd5);
    issue("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
    issue("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'd0);
    drain();

    // Start held high with changing operands: only the first request counts until the unit frees.
    @(negedge clk);
    wait_idle();
    drive(3'd0, 32'd3, 32'd5, 5'd13);
    sbq.push_back('{32'd15, 5'd13, cyc + WIDTH + 1, "hold_first"});
    accepted2 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.o_busy) begin
        drive(3'd5, 32'd100, 32'd7, 5'd14);
        sbq.push_back('{32'd14, 5'd14, cyc + WIDTH + 1, "hold_second"});
        accepted2 = 1'b1;
        break;
      end
      drive(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom));
    end
    if (!accepted2) fail_now("hold_second_not_accepted");
    @(negedge clk);
    bus.i_start = 1'b0;
    drain();

    // Reset in the middle of a divide discards it.
    @(negedge clk);
    wait_idle();
    drive(3'd4, 32'd1000, 32'd3, 5'd15);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (9) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check("midreset_busy", 64'(bus.o_busy), 64'd0);
    repeat (40) @(negedge clk);
    check("midreset_idle", 64'(bus.o_busy), 64'd0);

    // Randomized sweep against the reference model.
    for (int i = 0; i < 1500; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom);
      issue("rand", f, a, b, rd, ref_model(f, a, b));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
